// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 peripheral: synchronizes the SPI pins into clk, shifts
// 16-bit frames and commits valid writes into five 8-bit enable/duty registers.
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       copi_in,
  input  logic       ncs_in,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned ADDR_W     = 7;
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_BITS + 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR_L = ADDR_W'(MAX_ADDR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic                   r_sclk_prev;
  logic                   r_ncs_prev;

  logic [FRAME_BITS-1:0]  r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;

  logic w_sclk_s;
  logic w_ncs_s;
  logic w_copi_s;
  logic w_sclk_rise;
  logic w_ncs_fall;
  logic w_ncs_rise;
  logic w_we;

  // Synchronizers and edge-detect history, reset to idle bus levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_ncs_sync  <= '1;
      r_copi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ncs_prev  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs_in};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi_in};
      r_sclk_prev <= w_sclk_s;
      r_ncs_prev  <= w_ncs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_prev;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_ncs_fall) w_state_next = SHIFT;
      SHIFT:   if (w_ncs_rise) w_state_next = COMMIT;
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Shift path; an SCLK edge coincident with ncs rising belongs to no frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == IDLE && w_ncs_fall) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == SHIFT && w_sclk_rise && !w_ncs_rise) begin
      r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_s};
      if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  assign w_we = (r_state == COMMIT) && (r_bit_cnt == CNT_FULL) &&
                r_shift[15] && (r_shift[14:8] <= MAX_ADDR_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else if (w_we) begin
      case (r_shift[14:8])
        7'd0:    en_reg_out_7_0  <= r_shift[7:0];
        7'd1:    en_reg_out_15_8 <= r_shift[7:0];
        7'd2:    en_reg_pwm_7_0  <= r_shift[7:0];
        7'd3:    en_reg_pwm_15_8 <= r_shift[7:0];
        7'd4:    pwm_duty_cycle  <= r_shift[7:0];
        default: ;
      endcase
    end
  end

endmodule
